// File: rtl/amm_ram_slave.sv
// amm_ram_slave: Avalon-MM RAM responder with pipelined read, byte-enabled write and per-port waitrequest stalls
module amm_ram_slave #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 10,
   parameter int BYTE_CNT   = DATA_WIDTH / 8,
   parameter int RD_LATENCY = 2,
   parameter int RD_STALL   = 0,
   parameter int WR_STALL   = 0
) (
   input  logic                  clk_i,
   input  logic                  srst_i,
   input  logic [ADDR_WIDTH-1:0] amm_rd_address_i,
   input  logic                  amm_rd_read_i,
   output logic [DATA_WIDTH-1:0] amm_rd_readdata_o,
   output logic                  amm_rd_readdatavalid_o,
   output logic                  amm_rd_waitrequest_o,
   input  logic [ADDR_WIDTH-1:0] amm_wr_address_i,
   input  logic                  amm_wr_write_i,
   input  logic [DATA_WIDTH-1:0] amm_wr_writedata_i,
   input  logic [BYTE_CNT-1:0]   amm_wr_byteenable_i,
   output logic                  amm_wr_waitrequest_o,
   output logic [15:0]           rd_cnt_o,
   output logic [15:0]           wr_cnt_o
);
   localparam int RSW = RD_STALL > 0 ? $clog2(RD_STALL + 1) : 1;
   localparam int WSW = WR_STALL > 0 ? $clog2(WR_STALL + 1) : 1;
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [RD_LATENCY-1:0] vld;
   logic [DATA_WIDTH-1:0] dat [RD_LATENCY];
   logic [RSW-1:0]        rd_stall_cnt;
   logic [WSW-1:0]        wr_stall_cnt;
   logic                  rd_acc;
   logic                  wr_acc;
   assign rd_acc = amm_rd_read_i & ~amm_rd_waitrequest_o & ~srst_i;
   assign wr_acc = amm_wr_write_i & ~amm_wr_waitrequest_o & ~srst_i;
   assign amm_rd_waitrequest_o   = |rd_stall_cnt;
   assign amm_wr_waitrequest_o   = |wr_stall_cnt;
   assign amm_rd_readdatavalid_o = vld[RD_LATENCY-1];
   assign amm_rd_readdata_o      = dat[RD_LATENCY-1];
   // Memory is never reset; contents survive srst_i
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < BYTE_CNT; k++)
         if (wr_acc && amm_wr_byteenable_i[k])
            mem[amm_wr_address_i][8*k +: 8] <= amm_wr_writedata_i[8*k +: 8];
   end
   // Stage 0 loads zero when idle so readdata stays 0 outside valid reads
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         vld          <= '0;
         for (int i = 0; i < RD_LATENCY; i++) dat[i] <= '0;
         rd_stall_cnt <= '0;
         wr_stall_cnt <= '0;
         rd_cnt_o     <= '0;
         wr_cnt_o     <= '0;
      end else begin
         vld[0] <= rd_acc;
         dat[0] <= rd_acc ? mem[amm_rd_address_i] : '0;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
         end
         rd_stall_cnt <= (rd_acc && RD_STALL > 0) ? RSW'(RD_STALL) :
                         (rd_stall_cnt != '0) ? rd_stall_cnt - 1'b1 : rd_stall_cnt;
         wr_stall_cnt <= (wr_acc && WR_STALL > 0) ? WSW'(WR_STALL) :
                         (wr_stall_cnt != '0) ? wr_stall_cnt - 1'b1 : wr_stall_cnt;
         rd_cnt_o     <= rd_cnt_o + 16'(rd_acc);
         wr_cnt_o     <= wr_cnt_o + 16'(wr_acc);
      end
   end
endmodule
